// File: rtl/adc_stream_pkg.sv
// Shared types for the ADC sample stream: FSM states and the beat record
// that travels through the output FIFO.
package adc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ABORT
    } state_t;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic        tlast;
    } axis_beat_t;

    localparam int BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever empty is low. A push while full is accepted only when a pop
// frees the slot in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; entries are only read after
    // being written, and leaving the reset off lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_frame_packetizer.sv
// Packs pairs of ADC samples into 32-bit AXI-Stream beats and frames them on
// a trigger rising edge. A frame that cannot be buffered is cut short and
// closed with an empty tlast marker so the consumer can resynchronise.
module adc_frame_packetizer
    import adc_stream_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_BEATS  = 512,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_rst,
    input  logic [SAMPLE_WIDTH-1:0] adc_sample,
    input  logic                    adc_valid,
    input  logic                    trigger,
    input  logic                    clear_overflow,
    input  logic                    m00_axis_tready,
    output logic                    m00_axis_tvalid,
    output logic [31:0]             m00_axis_tdata,
    output logic [3:0]              m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    output logic [15:0]             frame_count,
    output logic                    overflow,
    output logic                    busy
);

    state_t                  state;
    logic                    trigger_q;
    logic [SAMPLE_WIDTH-1:0] low_half;
    logic                    have_low;
    logic [15:0]             beat_idx;
    axis_beat_t              pend_beat;
    logic                    pend_valid;

    logic                    fifo_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    axis_beat_t              fifo_din;
    axis_beat_t              fifo_dout;

    logic                    trig_edge;
    logic                    drop;
    logic                    last_pending;
    logic                    take_sample;

    assign trig_edge    = trigger & ~trigger_q;
    // When full, tvalid is high, so tready alone decides whether a slot frees up.
    assign drop         = (state == CAPTURE) & pend_valid & fifo_full & ~m00_axis_tready;
    assign last_pending = pend_valid & pend_beat.tlast;
    // Once the closing beat is formed, later samples belong to no frame.
    assign take_sample  = (state == CAPTURE) & adc_valid & ~last_pending & ~drop;

    // Select what enters the FIFO: the packed beat while capturing, the marker while aborting.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '0;
        case (state)
            CAPTURE: begin
                fifo_push = pend_valid;
                fifo_din  = pend_beat;
            end
            ABORT: begin
                fifo_push = ~fifo_full;
                fifo_din  = '{tdata: '0, tstrb: 4'h0, tlast: 1'b1};
            end
            default: ;
        endcase
    end

    // Frame FSM with sample packing, beat numbering and the frame counter.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_count <= '0;
            beat_idx    <= '0;
            low_half    <= '0;
            have_low    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_beat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state       <= CAPTURE;
                        busy        <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        beat_idx    <= '0;
                        have_low    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    pend_valid <= 1'b0;
                    if (drop) begin
                        state <= ABORT;
                    end else begin
                        if (last_pending) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        if (take_sample) begin
                            if (have_low) begin
                                pend_valid <= 1'b1;
                                pend_beat  <= '{tdata: {adc_sample, low_half},
                                               tstrb: 4'hF,
                                               tlast: (beat_idx == 16'(FRAME_BEATS - 1))};
                                beat_idx   <= beat_idx + 16'd1;
                                have_low   <= 1'b0;
                            end else begin
                                low_half <= adc_sample;
                                have_low <= 1'b1;
                            end
                        end
                    end
                end
                ABORT: begin
                    if (!fifo_full) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Edge detector history and the sticky overflow flag; a new overflow beats a clear.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_rst) begin
            trigger_q <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            trigger_q <= trigger;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    axis_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (m00_axis_aclk),
        .rst   (m00_axis_rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (m00_axis_tready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Hold the payload at zero while nothing is offered so reset leaves every output low.
    assign m00_axis_tvalid = ~fifo_empty;
    assign m00_axis_tdata  = fifo_empty ? 32'h0 : fifo_dout.tdata;
    assign m00_axis_tstrb  = fifo_empty ? 4'h0  : fifo_dout.tstrb;
    assign m00_axis_tlast  = fifo_empty ? 1'b0  : fifo_dout.tlast;

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Bench for adc_frame_packetizer: directed frame scenarios followed by a
// random phase, all checked cycle by cycle against a queue-based model.
module tb_adc_frame_packetizer;

    localparam int FB = 8;
    localparam int FD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] adc_sample;
    logic        adc_valid;
    logic        trigger;
    logic        clear_overflow;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [15:0] frame_count;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    adc_frame_packetizer #(
        .SAMPLE_WIDTH (16),
        .FRAME_BEATS  (FB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_rst    (rst),
        .adc_sample      (adc_sample),
        .adc_valid       (adc_valid),
        .trigger         (trigger),
        .clear_overflow  (clear_overflow),
        .m00_axis_tready (tready),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .frame_count     (frame_count),
        .overflow        (overflow),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: beats are {tdata, tstrb, tlast} = 37 bits.
    bit          m_cap;
    bit          m_abt;
    bit          m_trig_q;
    logic [15:0] m_fc;
    bit          m_ovf;
    logic [15:0] m_even;
    bit          m_has_even;
    int          m_beats;
    bit          m_pend_v;
    logic [36:0] m_pend;
    logic [36:0] m_fifo[$];
    logic [36:0] dut_rx[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [36:0] beat(input logic [15:0] hi, input logic [15:0] lo, input bit last);
        return {hi, lo, 4'hF, last};
    endfunction

    task automatic model_update();
        bit          pop;
        bit          full;
        bit          drop;
        bit          push;
        bit          last_p;
        bit          new_v;
        logic [36:0] item;
        logic [36:0] new_b;
        if (rst) begin
            m_cap = 0; m_abt = 0; m_trig_q = 0; m_fc = '0; m_ovf = 0;
            m_even = '0; m_has_even = 0; m_beats = 0; m_pend_v = 0; m_pend = '0;
            m_fifo.delete();
            return;
        end
        pop   = (m_fifo.size() > 0) && tready;
        full  = (m_fifo.size() == FD);
        drop  = 0; push = 0; new_v = 0; item = '0; new_b = '0;
        if (m_cap) begin
            last_p = m_pend_v && m_pend[0];
            if (m_pend_v) begin
                if (full && !tready) drop = 1;
                else begin push = 1; item = m_pend; end
            end
            if (drop) begin
                m_cap = 0; m_abt = 1;
            end else if (last_p) begin
                m_cap = 0;
            end else if (adc_valid) begin
                if (m_has_even) begin
                    new_v = 1;
                    new_b = beat(adc_sample, m_even, m_beats == FB - 1);
                    m_beats++;
                    m_has_even = 0;
                end else begin
                    m_even = adc_sample;
                    m_has_even = 1;
                end
            end
        end else if (m_abt) begin
            if (!full) begin push = 1; item = 37'h1; m_abt = 0; end
        end else if (trigger && !m_trig_q) begin
            m_cap = 1; m_fc++; m_beats = 0; m_has_even = 0;
        end
        m_trig_q = trigger;
        if (drop) m_ovf = 1;
        else if (clear_overflow) m_ovf = 0;
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(item);
        m_pend_v = new_v;
        m_pend   = new_b;
    endtask

    task automatic check_outputs();
        check("tvalid", tvalid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("beat", {tdata, tstrb, tlast}, m_fifo[0]);
        check("frame_count", frame_count, m_fc);
        check("overflow", overflow, m_ovf);
        check("busy", busy, m_cap || m_abt);
    endtask

    // One clock: compare at negedge, drive, log any transfer, advance the model.
    task automatic step(input bit t, input bit v, input logic [15:0] s, input bit rd,
                        input bit c = 0, input bit r = 0);
        @(negedge clk);
        check_outputs();
        trigger = t; adc_valid = v; adc_sample = s; tready = rd;
        clear_overflow = c; rst = r;
        if (tvalid && rd && !r) dut_rx.push_back({tdata, tstrb, tlast});
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_frame(input string tag, input int base);
        check({tag, "_len"}, dut_rx.size(), FB);
        for (int k = 0; k < FB && k < dut_rx.size(); k++)
            check($sformatf("%s_b%0d", tag, k), dut_rx[k],
                  beat(16'(base + 2*k + 2), 16'(base + 2*k + 1), k == FB - 1));
    endtask

    task automatic run_frame(input int base, input bit toggle);
        step(1, 0, 16'h0, 1);
        for (int i = 1; i <= 2*FB; i++) step(0, 1, 16'(base + i), toggle ? bit'(i % 2) : 1'b1);
        for (int i = 0; i < 12; i++) step(0, 0, 16'h0, toggle ? bit'(i % 2) : 1'b1);
    endtask

    initial begin
        int hits;
        rst = 1; trigger = 0; adc_valid = 0; adc_sample = '0; tready = 0; clear_overflow = 0;
        repeat (2) begin @(posedge clk); model_update(); end
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_fc", frame_count, 16'd0);
        check("rst_busy", busy, 1'b0);

        // Basic frame with tready held high.
        run_frame(0, 0);
        check_frame("t1", 0);
        check("t1_fc", frame_count, 16'd1);

        // Sample coincident with the trigger edge is dropped.
        dut_rx.delete();
        step(1, 1, 16'hAAAA, 1);
        for (int i = 1; i <= 2*FB; i++) step(0, 1, 16'(i), 1);
        repeat (6) step(0, 0, 16'h0, 1);
        check_frame("t2", 0);
        hits = 0;
        foreach (dut_rx[k]) if (dut_rx[k][20:5] == 16'hAAAA || dut_rx[k][36:21] == 16'hAAAA) hits++;
        check("t2_no_aaaa", hits, 0);

        // Backpressure for the whole frame forces an abort.
        dut_rx.delete();
        step(1, 0, 16'h0, 0);
        for (int i = 1; i <= 2*FB; i++) step(0, 1, 16'(i), 0);
        repeat (3) step(0, 0, 16'h0, 0);
        check("t3_ovf", overflow, 1'b1);
        check("t3_busy_held", busy, 1'b1);
        repeat (8) step(0, 0, 16'h0, 1);
        check("t3_len", dut_rx.size(), FD + 1);
        for (int k = 0; k < FD && k < dut_rx.size(); k++)
            check($sformatf("t3_b%0d", k), dut_rx[k], beat(16'(2*k + 2), 16'(2*k + 1), 0));
        if (dut_rx.size() > FD) check("t3_marker", dut_rx[FD], 37'h1);
        check("t3_busy_done", busy, 1'b0);
        step(0, 0, 16'h0, 1, 1);
        step(0, 0, 16'h0, 1);
        check("t3_ovf_clr", overflow, 1'b0);

        // tready toggling every cycle.
        dut_rx.delete();
        run_frame(100, 1);
        check_frame("t4", 100);

        // Retrigger inside CAPTURE is ignored.
        dut_rx.delete();
        step(1, 0, 16'h0, 1);
        for (int i = 1; i <= 2*FB; i++) step(i >= 7 && i <= 10, 1, 16'(i), 1);
        repeat (6) step(0, 0, 16'h0, 1);
        check("t5_fc", frame_count, 16'd5);
        check_frame("t5a", 0);
        dut_rx.delete();
        run_frame(0, 0);
        check("t5_fc2", frame_count, 16'd6);
        check_frame("t5b", 0);

        // Reset in the middle of a frame.
        step(1, 0, 16'h0, 1);
        for (int i = 1; i <= 5; i++) step(0, 1, 16'(i), 1);
        step(0, 0, 16'h0, 1, 0, 1);
        check("t6_tvalid", tvalid, 1'b0);
        check("t6_fc", frame_count, 16'd0);
        check("t6_busy", busy, 1'b0);
        dut_rx.delete();
        run_frame(200, 0);
        check_frame("t6", 200);
        check("t6_fc2", frame_count, 16'd1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 19) == 0, ($urandom % 4) != 0, 16'($urandom),
                 ($urandom % 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
